// File: rtl/ccc_reconfig_ctrl_pkg.sv
// rtl/ccc_reconfig_ctrl_pkg.sv - shared types and constants for the CCC reconfiguration sequencer
package ccc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    UPDATE    = 2'd2,
    WAIT_LOCK = 2'd3
  } ccc_state_e;

  localparam int CCC_CFG_W_DEF = 81;

  // Bit offsets of the divider fields inside the serial configuration word
  localparam int OADIV_OFS  = 0;
  localparam int OBDIV_OFS  = 5;
  localparam int OCDIV_OFS  = 10;
  localparam int FINDIV_OFS = 15;
  localparam int FBDIV_OFS  = 22;

endpackage

// File: rtl/ccc_reconfig_ctrl_if.sv
// rtl/ccc_reconfig_ctrl_if.sv - request and CCC dynamic-config signals of the reconfiguration sequencer
interface ccc_reconfig_ctrl_if
  import ccc_ctrl_pkg::*;
#(
  parameter int CFG_W = CCC_CFG_W_DEF
);
  logic             cfg_req;
  logic [CFG_W-1:0] cfg_word;
  logic             cfg_ack;
  logic             busy;
  logic             done;
  logic             err;
  logic             stat_ok;
  logic             sclk;
  logic             sdin;
  logic             sshift;
  logic             supdate;
  logic             lock_in;
  logic             locked;
  logic             lock_lost;

  modport master (
    output cfg_req, cfg_word, lock_in,
    input  cfg_ack, busy, done, err, stat_ok, sclk, sdin, sshift, supdate, locked, lock_lost
  );

  modport slave (
    input  cfg_req, cfg_word, lock_in,
    output cfg_ack, busy, done, err, stat_ok, sclk, sdin, sshift, supdate, locked, lock_lost
  );
endinterface

// File: rtl/ccc_reconfig_ctrl_lock_sync.sv
// rtl/ccc_reconfig_ctrl_lock_sync.sv - two-flop synchroniser for the asynchronous CCC lock
module ccc_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end
endmodule

// File: rtl/ccc_reconfig_ctrl.sv
// rtl/ccc_reconfig_ctrl.sv - serialises a CCC config word, strobes update, waits for lock with timeout
// Optional sticky lock-loss monitor built only when CCC_LOCK_MONITOR_EN is defined.
module ccc_reconfig_ctrl
  import ccc_ctrl_pkg::*;
#(
  parameter int CFG_W       = CCC_CFG_W_DEF,
  parameter int SCLK_DIV    = 2,
  parameter int LOCK_TMO    = 4096,
  parameter int LOCK_STABLE = 16
) (
  input logic                clk,
  input logic                rst,
  ccc_reconfig_ctrl_if.slave bus
);
  localparam int PH_W  = $clog2(2 * SCLK_DIV);
  localparam int BIT_W = $clog2(CFG_W);
  localparam int TMO_W = $clog2(LOCK_TMO + 1);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * SCLK_DIV - 1);
  localparam logic [PH_W-1:0]  SCLK_HI  = PH_W'(SCLK_DIV);
  localparam logic [PH_W-1:0]  UPD_LAST = PH_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TMO);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(LOCK_STABLE);

  ccc_state_e       state, state_nxt;
  logic [CFG_W-1:0] sr;
  logic [PH_W-1:0]  ph;
  logic [BIT_W-1:0] bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [STB_W-1:0] stb_cnt;
  logic             locked;
  logic             cfg_ack_q, done_q, err_q, stat_ok_q;

  logic accept, bit_end, last_bit, upd_end, lock_ok, lock_tmo;

  assign accept   = (state == IDLE) && bus.cfg_req;
  assign bit_end  = (ph == PH_LAST);
  assign last_bit = (bit_cnt == BIT_LAST);
  assign upd_end  = (ph == UPD_LAST);
  assign lock_ok  = (stb_cnt == STB_MAX);
  assign lock_tmo = (tmo_cnt == TMO_MAX);

  ccc_lock_sync u_lock_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.lock_in),
    .sync_out (locked)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.cfg_req)         state_nxt = SHIFT;
      SHIFT:     if (bit_end && last_bit) state_nxt = UPDATE;
      UPDATE:    if (upd_end)             state_nxt = WAIT_LOCK;
      WAIT_LOCK: if (lock_ok || lock_tmo) state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.sshift  = 1'b0;
    bus.sclk    = 1'b0;
    bus.sdin    = 1'b0;
    bus.supdate = 1'b0;
    case (state)
      SHIFT: begin
        bus.sshift = 1'b1;
        bus.sclk   = (ph >= SCLK_HI);
        bus.sdin   = sr[0];
      end
      UPDATE:  bus.supdate = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.cfg_ack = cfg_ack_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.stat_ok = stat_ok_q;
  assign bus.locked  = locked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      ph        <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      stb_cnt   <= '0;
      cfg_ack_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      stat_ok_q <= 1'b0;
    end else begin
      cfg_ack_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          sr        <= bus.cfg_word;
          ph        <= '0;
          bit_cnt   <= '0;
          cfg_ack_q <= 1'b1;
          stat_ok_q <= 1'b0;
        end
        SHIFT: begin
          // end of the SCLK high phase is the falling edge: advance to the next bit
          if (bit_end) begin
            ph <= '0;
            sr <= sr >> 1;
            if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        UPDATE: begin
          if (upd_end) begin
            ph      <= '0;
            tmo_cnt <= '0;
            stb_cnt <= '0;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (!lock_tmo) tmo_cnt <= tmo_cnt + 1'b1;
          if (!locked)      stb_cnt <= '0;
          else if (!lock_ok) stb_cnt <= stb_cnt + 1'b1;
          // success takes priority over a coincident timeout
          if (lock_ok) begin
            done_q    <= 1'b1;
            stat_ok_q <= 1'b1;
          end else if (lock_tmo) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CCC_LOCK_MONITOR_EN
  logic lock_lost_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        lock_lost_q <= 1'b0;
    else if (accept)                                lock_lost_q <= 1'b0;
    else if ((state == IDLE) && stat_ok_q && !locked) lock_lost_q <= 1'b1;
  end

  assign bus.lock_lost = lock_lost_q;
`else
  assign bus.lock_lost = 1'b0;
`endif

endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// tb/tb_ccc_reconfig_ctrl.sv - scoreboard bench for the CCC reconfiguration sequencer
module tb_ccc_reconfig_ctrl;
  localparam int CFG_W       = 81;
  localparam int SCLK_DIV    = 2;
  localparam int LOCK_TMO    = 4096;
  localparam int LOCK_STABLE = 16;

  localparam int M_HIGH   = 0;
  localparam int M_LOW    = 1;
  localparam int M_TOGGLE = 2;
  localparam int M_EDGE   = 3;

  localparam logic [CFG_W-1:0] W_A5 = 81'h1_0000_0000_0000_0000_00A5;

  typedef struct {
    bit is_done;
    int k;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic bit_q[$];
  res_t res_q[$];

  always #5 clk = ~clk;

  ccc_reconfig_ctrl_if #(.CFG_W(CFG_W)) bus ();

  ccc_reconfig_ctrl #(
    .CFG_W       (CFG_W),
    .SCLK_DIV    (SCLK_DIV),
    .LOCK_TMO    (LOCK_TMO),
    .LOCK_STABLE (LOCK_STABLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one request; abort_bit >= 0 asserts reset at the start of that bit.
  task automatic run_seq(input logic [CFG_W-1:0] word, input int mode, input int abort_bit);
    int   ph = 0, nbits = 0, nshift = 0, nupd = 0, nack = 0, sclk_bad = 0, k = 0;
    int   lock_start = LOCK_TMO - LOCK_STABLE - 2;
    bit   in_wait = 0, prev_upd = 0, fin = 0;
    res_t e;
    for (int i = 0; i < CFG_W; i++) bit_q.push_back(word[i]);
    if (abort_bit < 0) begin
      e.is_done = (mode == M_HIGH) || (mode == M_EDGE);
      e.k       = (mode == M_HIGH) ? LOCK_STABLE + 1 : LOCK_TMO + 1;
      res_q.push_back(e);
    end
    bus.lock_in  = (mode == M_HIGH);
    bus.cfg_word = word;
    bus.cfg_req  = 1'b1;
    for (int cyc = 0; cyc < 2 * CFG_W * SCLK_DIV + SCLK_DIV + LOCK_TMO + 100; cyc++) begin
      @(negedge clk);
      if (bus.cfg_ack) begin
        nack++;
        if (nack == 1) begin
          check("busy_on_ack", bus.busy, 1);
          check("stat_ok_clr", bus.stat_ok, 0);
          check("lock_lost_clr", bus.lock_lost, 0);
        end
      end
      if (bus.sshift) begin
        if (ph == 0) begin
          if (nbits == abort_bit) begin
            rst = 1'b1;
            #1;
            check("abort_outs", {bus.sshift, bus.sclk, bus.sdin, bus.busy, bus.supdate, bus.cfg_ack}, 0);
            check("abort_no_update", nupd, 0);
            bit_q.delete();
            bus.cfg_req = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            fin = 1;
            break;
          end else if (bit_q.size() == 0) begin
            check("sdin_underflow", 1, 0);
          end else begin
            check($sformatf("sdin[%0d]", nbits), bus.sdin, bit_q.pop_front());
          end
          nbits++;
        end
        if (bus.sclk !== (ph >= SCLK_DIV)) sclk_bad++;
        ph = (ph == 2 * SCLK_DIV - 1) ? 0 : ph + 1;
        nshift++;
      end else begin
        ph = 0;
      end
      if (bus.supdate) nupd++;
      if (!in_wait && prev_upd && !bus.supdate) begin
        in_wait = 1;
        k = 0;
      end
      prev_upd = bus.supdate;
      if (in_wait) begin
        if (bus.done || bus.err) begin
          if (res_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = res_q.pop_front();
            check("result_done", bus.done, e.is_done);
            check("result_err", bus.err, !e.is_done);
            check("lock_latency", k, e.k);
            check("stat_ok", bus.stat_ok, e.is_done);
          end
          check("busy_off", bus.busy, 0);
          check("ack_count", nack, 1);
          check("sshift_cycles", nshift, CFG_W * 2 * SCLK_DIV);
          check("supdate_cycles", nupd, SCLK_DIV);
          check("sclk_shape", sclk_bad, 0);
          check("bits_left", bit_q.size(), 0);
          bus.cfg_req = 1'b0;
          fin = 1;
          break;
        end
        if (mode == M_TOGGLE)
          bus.lock_in = ((k / 8) % 2 == 1);
        else if (mode == M_EDGE)
          bus.lock_in = (k >= lock_start) ? 1'b1 : (k == lock_start - 1) ? 1'b0 : ((k / 8) % 2 == 1);
        k++;
      end
    end
    if (!fin) begin
      check("seq_timeout", 0, 1);
      bus.cfg_req = 1'b0;
    end
  endtask

  initial begin
    logic [CFG_W-1:0] w;
    bus.cfg_req  = 1'b0;
    bus.cfg_word = '0;
    bus.lock_in  = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs", {bus.cfg_ack, bus.busy, bus.done, bus.err, bus.stat_ok, bus.sclk, bus.sdin,
                       bus.sshift, bus.supdate, bus.locked, bus.lock_lost}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("locked_1cyc", bus.locked, 0);
    @(negedge clk);
    check("locked_2cyc", bus.locked, 1);

    run_seq(W_A5, M_HIGH, -1);

    @(negedge clk);
    check("lock_lost_quiet", bus.lock_lost, 0);
    bus.lock_in = 1'b0;
    @(negedge clk);
    bus.lock_in = 1'b1;
    repeat (4) @(negedge clk);
`ifdef CCC_LOCK_MONITOR_EN
    check("lock_lost_set", bus.lock_lost, 1);
`else
    check("lock_lost_tied", bus.lock_lost, 0);
`endif

    w = CFG_W'({$urandom(), $urandom(), $urandom()});
    run_seq(w, M_LOW, -1);
    w = CFG_W'({$urandom(), $urandom(), $urandom()});
    run_seq(w, M_TOGGLE, -1);
    w = CFG_W'({$urandom(), $urandom(), $urandom()});
    run_seq(w, M_EDGE, -1);
    w = CFG_W'({$urandom(), $urandom(), $urandom()});
    run_seq(w, M_HIGH, 40);
    w = CFG_W'({$urandom(), $urandom(), $urandom()});
    run_seq(w, M_HIGH, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
